// File: rtl/ifu.sv
// Instruction fetch unit: holds the PC, fetches one word at a time, and steps the PC on writeback.
// Build option IFU_ALIGN_CHECK_EN: a misaligned taken branch faults instead of being realigned.
//   state | meaning
//   IDLE  | one-cycle pause after reset
//   REQ   | fetch request presented at pc
//   WAIT  | request accepted, awaiting response
//   EXEC  | inst/pc valid, waiting for wb_done
//   FAULT | fetch fault, sticky until rst
module ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [63:0] pc,
  input  logic        wb_done,
  input  logic        branch,
  input  logic [63:0] branch_target,
  output logic        fetch_fault,
  output logic [63:0] retired
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, EXEC, FAULT} state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [63:0] retired_q, retired_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= NOP;
      retired_q <= 64'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    retired_d = retired_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          if (imem_rsp_err) begin
            state_d = FAULT;
          end else begin
            inst_d  = imem_rsp_data;
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        if (wb_done) begin
          retired_d = retired_q + 64'd1;
          state_d   = REQ;
          if (branch) begin
`ifdef IFU_ALIGN_CHECK_EN
            pc_d = branch_target;
            if (branch_target[1:0] != 2'b00) state_d = FAULT;
`else
            // Low bits dropped so fetches stay word aligned.
            pc_d = branch_target & ~64'h3;
`endif
          end else begin
            pc_d = pc_q + 64'd4;
          end
        end
      end
      FAULT: state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  assign imem_req_valid = (state_q == REQ);
  assign imem_req_addr  = pc_q;
  assign inst           = inst_q;
  assign inst_valid     = (state_q == EXEC);
  assign pc             = pc_q;
  assign fetch_fault    = (state_q == FAULT);
  assign retired        = retired_q;

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: per-cycle vector table plus a few hand-written timing sequences.
// Honours IFU_ALIGN_CHECK_EN for the misaligned-branch expectations.
module tb_ifu;

  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;
  localparam logic [63:0] BT  = 64'h0000_0000_8000_1000;
  localparam logic [63:0] MIS = 64'h0000_0000_8000_0002;
  localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid, imem_rsp_err;
  logic [31:0] imem_rsp_data;
  logic [31:0] inst;
  logic        inst_valid;
  logic [63:0] pc;
  logic        wb_done, branch;
  logic [63:0] branch_target;
  logic        fetch_fault;
  logic [63:0] retired;

  int total = 0;
  int bad   = 0;

  ifu dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .imem_rsp_err(imem_rsp_err),
    .inst(inst), .inst_valid(inst_valid), .pc(pc),
    .wb_done(wb_done), .branch(branch), .branch_target(branch_target),
    .fetch_fault(fetch_fault), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, rdy, rv;
    logic [31:0] rdata;
    logic        rerr, wb, br;
    logic [63:0] tgt;
    logic        e_rqv;
    logic [63:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [63:0] e_pc;
    logic        e_ff;
    logic [63:0] e_ret;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic r, rdy, rv, input logic [31:0] d,
                              input logic er, wb, br, input logic [63:0] t,
                              input logic qv, input logic [63:0] a, input logic iv,
                              input logic [31:0] ei, input logic [63:0] ep,
                              input logic ff, input logic [63:0] ret);
    vec_t x;
    x.rst = r; x.rdy = rdy; x.rv = rv; x.rdata = d; x.rerr = er;
    x.wb = wb; x.br = br; x.tgt = t;
    x.e_rqv = qv; x.e_addr = a; x.e_iv = iv; x.e_inst = ei;
    x.e_pc = ep; x.e_ff = ff; x.e_ret = ret;
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp, input int row);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%h want=%h", name, row, act, exp);
    end
  endtask

  task automatic drive_idle();
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 32'h0;
    imem_rsp_err = 0; wb_done = 0; branch = 0; branch_target = 64'h0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);

    //                r  rdy rv data          er wb br tgt    rqv addr       iv inst          pc         ff ret
    vq.push_back(mk(1, 0, 0, 32'h0,         0, 0, 0, 64'h0, 0, RPC,        0, NOP,          RPC,        0, 0));
    vq.push_back(mk(0, 1, 0, 32'h0,         0, 0, 0, 64'h0, 0, RPC,        0, NOP,          RPC,        0, 0));
    vq.push_back(mk(0, 1, 0, 32'h0,         0, 0, 0, 64'h0, 1, RPC,        0, NOP,          RPC,        0, 0));
    vq.push_back(mk(0, 0, 1, 32'h00500093,  0, 0, 0, 64'h0, 0, RPC,        0, NOP,          RPC,        0, 0));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 0, 1, BT,    0, RPC,        1, 32'h00500093, RPC,        0, 0));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 1, 0, 64'h0, 0, RPC,        1, 32'h00500093, RPC,        0, 0));
    // ready held low for 5 cycles with a stray response
    vq.push_back(mk(0, 0, 1, 32'hBAD0BAD0,  1, 0, 0, 64'h0, 1, RPC+4,      0, 32'h00500093, RPC+4,      0, 1));
    for (int i = 0; i < 4; i++)
      vq.push_back(mk(0, 0, 1, 32'hBAD0BAD0, 0, 1, 1, BT, 1, RPC+4,       0, 32'h00500093, RPC+4,      0, 1));
    vq.push_back(mk(0, 1, 0, 32'h0,         0, 0, 0, 64'h0, 1, RPC+4,      0, 32'h00500093, RPC+4,      0, 1));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 1, 1, BT,    0, RPC+4,      0, 32'h00500093, RPC+4,      0, 1));
    vq.push_back(mk(0, 0, 1, 32'h00A00113,  0, 0, 0, 64'h0, 0, RPC+4,      0, 32'h00500093, RPC+4,      0, 1));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 1, 1, BT,    0, RPC+4,      1, 32'h00A00113, RPC+4,      0, 1));
    vq.push_back(mk(0, 1, 0, 32'h0,         0, 0, 0, 64'h0, 1, BT,         0, 32'h00A00113, BT,         0, 2));
    vq.push_back(mk(0, 0, 1, 32'h12345678,  0, 0, 0, 64'h0, 0, BT,         0, 32'h00A00113, BT,         0, 2));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 1, 1, MIS,   0, BT,         1, 32'h12345678, BT,         0, 2));
`ifdef IFU_ALIGN_CHECK_EN
    vq.push_back(mk(1, 1, 0, 32'h0,         0, 0, 0, 64'h0, 0, MIS,        0, 32'h12345678, MIS,        1, 3));
`else
    vq.push_back(mk(1, 1, 0, 32'h0,         0, 0, 0, 64'h0, 1, RPC,        0, 32'h12345678, RPC,        0, 3));
`endif
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 64'h0, 0, RPC,        0, NOP,          RPC,        0, 0));
    vq.push_back(mk(0, 1, 0, 32'h0,         0, 0, 0, 64'h0, 1, RPC,        0, NOP,          RPC,        0, 0));
    vq.push_back(mk(0, 0, 1, 32'hDEADBEEF,  1, 0, 0, 64'h0, 0, RPC,        0, NOP,          RPC,        0, 0));
    vq.push_back(mk(0, 1, 1, 32'h00000093,  0, 1, 0, 64'h0, 0, RPC,        0, NOP,          RPC,        1, 0));
    vq.push_back(mk(0, 1, 1, 32'h00000093,  0, 1, 1, BT,    0, RPC,        0, NOP,          RPC,        1, 0));
    vq.push_back(mk(1, 0, 0, 32'h0,         0, 0, 0, 64'h0, 0, RPC,        0, NOP,          RPC,        1, 0));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 64'h0, 0, RPC,        0, NOP,          RPC,        0, 0));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 64'h0, 1, RPC,        0, NOP,          RPC,        0, 0));
    vq.push_back(mk(0, 1, 0, 32'h0,         0, 0, 0, 64'h0, 1, RPC,        0, NOP,          RPC,        0, 0));
    // reset while waiting for a response
    vq.push_back(mk(1, 0, 0, 32'h0,         0, 0, 0, 64'h0, 0, RPC,        0, NOP,          RPC,        0, 0));
    vq.push_back(mk(0, 0, 1, 32'h11111111,  0, 0, 0, 64'h0, 0, RPC,        0, NOP,          RPC,        0, 0));
    vq.push_back(mk(0, 1, 0, 32'h0,         0, 0, 0, 64'h0, 1, RPC,        0, NOP,          RPC,        0, 0));
    vq.push_back(mk(0, 0, 1, 32'h00000013,  0, 0, 0, 64'h0, 0, RPC,        0, NOP,          RPC,        0, 0));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 1, 1, TOP,   0, RPC,        1, NOP,          RPC,        0, 0));
    vq.push_back(mk(0, 1, 0, 32'h0,         0, 0, 0, 64'h0, 1, TOP,        0, NOP,          TOP,        0, 1));
    vq.push_back(mk(0, 0, 1, 32'h00000073,  0, 0, 0, 64'h0, 0, TOP,        0, NOP,          TOP,        0, 1));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 1, 0, 64'h0, 0, TOP,        1, 32'h00000073, TOP,        0, 1));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 64'h0, 1, 64'h0,      0, 32'h00000073, 64'h0,      0, 2));

    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].rst; imem_req_ready = vq[i].rdy; imem_rsp_valid = vq[i].rv;
      imem_rsp_data = vq[i].rdata; imem_rsp_err = vq[i].rerr;
      wb_done = vq[i].wb; branch = vq[i].br; branch_target = vq[i].tgt;
      chk("req_valid",  {63'h0, imem_req_valid}, {63'h0, vq[i].e_rqv}, i);
      chk("req_addr",   imem_req_addr,           vq[i].e_addr,         i);
      chk("inst_valid", {63'h0, inst_valid},     {63'h0, vq[i].e_iv},  i);
      chk("inst",       {32'h0, inst},           {32'h0, vq[i].e_inst}, i);
      chk("pc",         pc,                      vq[i].e_pc,           i);
      chk("fetch_fault",{63'h0, fetch_fault},    {63'h0, vq[i].e_ff},  i);
      chk("retired",    retired,                 vq[i].e_ret,          i);
    end

    // first request latency after reset release, then a bounded wait for EXEC
    @(negedge clk); drive_idle(); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    n = 0;
    while (!imem_req_valid && n < 10) begin
      @(negedge clk); n++;
    end
    chk("first_req_latency", 64'(n), 64'd1, -1);
    chk("first_req_addr", imem_req_addr, RPC, -1);
    imem_req_ready = 1'b1;
    @(negedge clk); imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hCAFE0013;
    n = 0;
    @(negedge clk); imem_rsp_valid = 1'b0;
    while (!inst_valid && n < 10) begin
      @(negedge clk); n++;
    end
    chk("rsp_to_exec_latency", 64'(n), 64'd0, -2);
    chk("exec_inst", {32'h0, inst}, {32'h0, 32'hCAFE0013}, -2);
    // two-cycle wb_done pulse: the second cycle is in REQ and must not count
    wb_done = 1'b1;
    @(negedge clk);
    @(negedge clk); wb_done = 1'b0;
    chk("retired_once", retired, 64'd1, -3);
    chk("next_addr", imem_req_addr, RPC + 64'd4, -3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
